// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: op encoding, reserved-op test
// and the per-stage pipeline record.
package shifter_pkg;

   // The stage record is sized for the widest supported operand; narrower
   // instances leave the upper data/amt bits at zero and synthesis drops them.
   localparam int MAX_WIDTH = 1024;
   localparam int MAX_SHW   = $clog2(MAX_WIDTH);

   typedef enum logic [2:0] {
      OP_SLL = 3'd0,
      OP_SRL = 3'd1,
      OP_SRA = 3'd2,
      OP_ROL = 3'd3,
      OP_ROR = 3'd4
   } shift_op_e;

   typedef struct packed {
      logic                 valid;
      logic [MAX_WIDTH-1:0] data;
      logic [2:0]           op;
      logic [MAX_SHW-1:0]   amt;
      logic                 err;
   } stage_rec_t;

   function automatic logic is_reserved_op(input logic [2:0] op);
      return op > 3'(OP_ROR);
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One binary stage of the pipelined shifter: conditionally shifts by 2^K and
// holds the result in a handshaked stage register.
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int K     = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  stage_rec_t i_rec,
   input  logic       i_next_ready,
   output logic       o_ready,
   output stage_rec_t o_rec
);

   localparam int S = 1 << K;

   logic [WIDTH-1:0] w_din;
   logic [WIDTH-1:0] w_shifted;
   stage_rec_t       w_next;
   stage_rec_t       r_rec;

   assign w_din = i_rec.data[WIDTH-1:0];

   // Reserved ops carry err and must reach the output unshifted.
   always_comb begin
      w_shifted = w_din;
      if (i_rec.amt[K] && !i_rec.err) begin
         case (shift_op_e'(i_rec.op))
            OP_SLL:  w_shifted = w_din << S;
            OP_SRL:  w_shifted = w_din >> S;
            OP_SRA:  w_shifted = {{S{w_din[WIDTH-1]}}, w_din[WIDTH-1:S]};
            OP_ROL:  w_shifted = {w_din[WIDTH-1-S:0], w_din[WIDTH-1:WIDTH-S]};
            OP_ROR:  w_shifted = {w_din[S-1:0], w_din[WIDTH-1:S]};
            default: w_shifted = w_din;
         endcase
      end
   end

   always_comb begin
      w_next                  = i_rec;
      w_next.data[WIDTH-1:0]  = w_shifted;
   end

   // Loading while upstream is invalid empties the stage, collapsing bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rec <= '0;
      end else if (o_ready) begin
         r_rec <= w_next;
      end
   end

   assign o_ready = !r_rec.valid || i_next_ready;
   assign o_rec   = r_rec;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered binary stage per shift-amount bit,
// valid/ready at both ends with ready chained combinationally from out_ready.
module pipelined_barrel_shifter
   import shifter_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err
);

   stage_rec_t w_in;
   logic       w_unused;

   if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("pipelined_barrel_shifter: WIDTH must be a power of two between 4 and %0d", MAX_WIDTH);
   end

   always_comb begin
      w_in                  = '0;
      w_in.valid            = in_valid;
      w_in.data[WIDTH-1:0]  = in_data;
      w_in.op               = in_op;
      w_in.amt[SHW-1:0]     = in_amt;
      w_in.err              = is_reserved_op(in_op);
   end

   // Stage k shifts by 2^k; each stage's ready feeds the stage before it.
   for (genvar k = 0; k < SHW; k++) begin : g_stage
      stage_rec_t w_prev;
      stage_rec_t w_out;
      logic       w_down;
      logic       w_rdy;

      if (k == 0) begin : g_first
         assign w_prev = w_in;
      end else begin : g_chain
         assign w_prev = g_stage[k-1].w_out;
      end

      if (k == SHW - 1) begin : g_last
         assign w_down = out_ready;
      end else begin : g_inner
         assign w_down = g_stage[k+1].w_rdy;
      end

      shift_stage #(
         .WIDTH (WIDTH),
         .K     (k)
      ) u_stage (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_rec        (w_prev),
         .i_next_ready (w_down),
         .o_ready      (w_rdy),
         .o_rec        (w_out)
      );
   end

   assign in_ready  = g_stage[0].w_rdy;
   assign out_valid = g_stage[SHW-1].w_out.valid;
   assign out_data  = g_stage[SHW-1].w_out.data[WIDTH-1:0];
   assign out_err   = g_stage[SHW-1].w_out.err;

   assign w_unused = ^{g_stage[SHW-1].w_out.op, g_stage[SHW-1].w_out.amt,
                       g_stage[SHW-1].w_out.data};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: WIDTH=16 feature tests plus
// a sweep over WIDTH=4/32/64 against a behavioural shift model.
module tb_pipelined_barrel_shifter;

   typedef struct packed {
      logic [15:0] data;
      logic        err;
   } exp_t;

   localparam int SHW16 = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_amt;
   logic [2:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_err;

   logic [2:0]        swInValid;
   logic [2:0][63:0]  swInData;
   logic [2:0][5:0]   swInAmt;
   logic [2:0][2:0]   swInOp;
   logic [2:0]        swOutValid;
   logic [2:0][63:0]  swOutData;

   int passCount  = 0;
   int checkCount = 0;

   exp_t        sbq[$];
   logic [63:0] swq[$];

   pipelined_barrel_shifter #(.WIDTH(16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   // Width-sweep instances, always draining (out_ready tied high).
   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int W  = (g == 0) ? 4 : (g == 1) ? 32 : 64;
      localparam int SH = $clog2(W);
      logic [W-1:0] wData;
      logic         wValid;
      logic         unusedErr;
      logic         unusedReady;

      pipelined_barrel_shifter #(.WIDTH(W)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (swInValid[g]),
         .in_ready  (unusedReady),
         .in_data   (swInData[g][W-1:0]),
         .in_amt    (swInAmt[g][SH-1:0]),
         .in_op     (swInOp[g]),
         .out_valid (wValid),
         .out_ready (1'b1),
         .out_data  (wData),
         .out_err   (unusedErr)
      );

      assign swOutValid[g] = wValid;
      assign swOutData[g]  = 64'(wData);
   end

   always #5 clk = ~clk;

   // Behavioural reference: whole-word shifts on a 64-bit container, masked to w.
   function automatic logic [63:0] refShift(input int w, input logic [2:0] op,
                                            input logic [63:0] a, input int amt);
      logic [63:0] mask;
      logic [63:0] r;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      a    = a & mask;
      case (op)
         3'd0: r = a << amt;
         3'd1: r = a >> amt;
         3'd2: begin
            r = a >> amt;
            if (a[w-1]) r = r | ~(mask >> amt);
         end
         3'd3: r = (a << amt) | (a >> (w - amt));
         3'd4: r = (a >> amt) | (a << (w - amt));
         default: r = a;
      endcase
      return r & mask;
   endfunction

   // Offers one op to the 16-bit DUT and reports edges from accept to out_valid.
   task automatic sendOne(input logic [2:0] op, input logic [15:0] a, input logic [3:0] amt,
                          output int edges, output logic [15:0] d, output logic e);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_op    = op;
      in_data  = a;
      in_amt   = amt;
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges    = 1;
      while (!out_valid && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      d = out_data;
      e = out_err;
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      in_op    = 3'd0;
      in_data  = 16'hFFFF;
      in_amt   = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkCount++;
      if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid);
      else passCount++;
      checkCount++;
      if (out_data !== 16'h0000) $display("[TB] FAIL reset_out_data: got %h, expected 0000", out_data);
      else passCount++;
      checkCount++;
      if (out_err !== 1'b0) $display("[TB] FAIL reset_out_err: got %b, expected 0", out_err);
      else passCount++;
      checkCount++;
      if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
      else passCount++;
      checkCount++;
      if (swOutValid !== 3'b000) $display("[TB] FAIL reset_sweep_valid: got %b, expected 000", swOutValid);
      else passCount++;
      in_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;
   endtask

   task automatic test_basic_ops();
      logic [2:0]  tOp  [4] = '{3'd0, 3'd1, 3'd2, 3'd2};
      logic [15:0] tA   [4] = '{16'h8001, 16'h8000, 16'h8000, 16'h4000};
      logic [3:0]  tAmt [4] = '{4'd1, 4'd15, 4'd15, 4'd14};
      logic [15:0] tExp [4] = '{16'h0002, 16'h0001, 16'hFFFF, 16'h0001};
      exp_t        x;
      int          edges;
      logic [15:0] d;
      logic        e;
      for (int i = 0; i < 4; i++) begin
         x.data = tExp[i];
         x.err  = 1'b0;
         sbq.push_back(x);
         sendOne(tOp[i], tA[i], tAmt[i], edges, d, e);
         x = sbq.pop_front();
         checkCount++;
         if (edges !== SHW16) $display("[TB] FAIL basic_latency[%0d]: got %0d edges, expected %0d", i, edges, SHW16);
         else passCount++;
         checkCount++;
         if (d !== x.data) $display("[TB] FAIL basic_data[%0d]: got %h, expected %h", i, d, x.data);
         else passCount++;
         checkCount++;
         if (e !== x.err) $display("[TB] FAIL basic_err[%0d]: got %b, expected %b", i, e, x.err);
         else passCount++;
      end
   endtask

   task automatic test_rotates();
      logic [2:0]  tOp  [4] = '{3'd3, 3'd4, 3'd3, 3'd4};
      logic [15:0] tA   [4] = '{16'h1234, 16'h1234, 16'hA5A5, 16'h0001};
      logic [3:0]  tAmt [4] = '{4'd4, 4'd4, 4'd0, 4'd15};
      logic [15:0] tExp [4] = '{16'h2341, 16'h4123, 16'hA5A5, 16'h0002};
      exp_t        x;
      int          edges;
      logic [15:0] d;
      logic        e;
      for (int i = 0; i < 4; i++) begin
         x.data = tExp[i];
         x.err  = 1'b0;
         sbq.push_back(x);
         sendOne(tOp[i], tA[i], tAmt[i], edges, d, e);
         x = sbq.pop_front();
         checkCount++;
         if (edges !== SHW16) $display("[TB] FAIL rotate_latency[%0d]: got %0d edges, expected %0d", i, edges, SHW16);
         else passCount++;
         checkCount++;
         if (d !== x.data) $display("[TB] FAIL rotate_data[%0d]: got %h, expected %h", i, d, x.data);
         else passCount++;
      end
   endtask

   task automatic test_reserved_op();
      logic [2:0]  tOp  [2] = '{3'd6, 3'd0};
      logic [15:0] tA   [2] = '{16'hBEEF, 16'h0001};
      logic [3:0]  tAmt [2] = '{4'd3, 4'd2};
      logic [15:0] tExp [2] = '{16'hBEEF, 16'h0004};
      logic        tErr [2] = '{1'b1, 1'b0};
      exp_t        x;
      int          edges;
      logic [15:0] d;
      logic        e;
      for (int i = 0; i < 2; i++) begin
         x.data = tExp[i];
         x.err  = tErr[i];
         sbq.push_back(x);
         sendOne(tOp[i], tA[i], tAmt[i], edges, d, e);
         x = sbq.pop_front();
         checkCount++;
         if (d !== x.data) $display("[TB] FAIL reserved_data[%0d]: got %h, expected %h", i, d, x.data);
         else passCount++;
         checkCount++;
         if (e !== x.err) $display("[TB] FAIL reserved_err[%0d]: got %b, expected %b", i, e, x.err);
         else passCount++;
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] aArr   [10];
      logic [2:0]  opArr  [10];
      logic [3:0]  amtArr [10];
      logic [63:0] r;
      logic [15:0] held;
      logic        holding;
      logic        sawFull;
      exp_t        x;
      int          sent;
      int          got;
      int          cyc;
      for (int i = 0; i < 10; i++) begin
         aArr[i]   = 16'($urandom);
         opArr[i]  = 3'($urandom_range(0, 4));
         amtArr[i] = 4'($urandom_range(0, 15));
      end
      sent    = 0;
      got     = 0;
      cyc     = 0;
      held    = '0;
      holding = 1'b0;
      sawFull = 1'b0;
      while (got < 10 && cyc < 200) begin
         @(posedge clk); #1;
         in_valid  = (sent < 10);
         if (sent < 10) begin
            in_op   = opArr[sent];
            in_data = aArr[sent];
            in_amt  = amtArr[sent];
         end
         out_ready = !(cyc >= 3 && cyc < 9);
         @(negedge clk);
         if (out_valid && out_ready) begin
            checkCount++;
            if (sbq.size() == 0) begin
               $display("[TB] FAIL b2b_spurious: got output %h, expected none", out_data);
            end else begin
               passCount++;
               x = sbq.pop_front();
               checkCount++;
               if (out_data !== x.data) $display("[TB] FAIL b2b_data[%0d]: got %h, expected %h", got, out_data, x.data);
               else passCount++;
            end
            got++;
            holding = 1'b0;
         end else if (out_valid) begin
            if (holding) begin
               checkCount++;
               if (out_data !== held) $display("[TB] FAIL b2b_stall_stable: got %h, expected %h", out_data, held);
               else passCount++;
            end else begin
               held    = out_data;
               holding = 1'b1;
            end
         end
         if (!in_ready) begin
            sawFull = 1'b1;
            checkCount++;
            if ((sent - got) !== SHW16) $display("[TB] FAIL b2b_occupancy: got %0d in flight, expected %0d", sent - got, SHW16);
            else passCount++;
         end
         if (in_valid && in_ready) begin
            r      = refShift(16, opArr[sent], 64'(aArr[sent]), int'(amtArr[sent]));
            x.data = r[15:0];
            x.err  = 1'b0;
            sbq.push_back(x);
            sent++;
         end
         cyc++;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkCount++;
      if (sawFull !== 1'b1) $display("[TB] FAIL b2b_in_ready_fell: got %b, expected 1", sawFull);
      else passCount++;
      checkCount++;
      if (got !== 10) $display("[TB] FAIL b2b_received: got %0d results, expected 10", got);
      else passCount++;
      checkCount++;
      if (sbq.size() !== 0) $display("[TB] FAIL b2b_leftover: got %0d pending, expected 0", sbq.size());
      else passCount++;
      sbq.delete();
   endtask

   task automatic test_reset_mid();
      exp_t x;
      int   edges;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_op    = 3'd0;
      in_amt   = 4'd1;
      for (int i = 0; i < 3; i++) begin
         in_data = 16'h0101 << i;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checkCount++;
      if (out_valid !== 1'b1) $display("[TB] FAIL rstmid_in_flight: got out_valid %b, expected 1", out_valid);
      else passCount++;
      #2;
      rst_n = 1'b0;
      #1;
      checkCount++;
      if (out_valid !== 1'b0) $display("[TB] FAIL rstmid_valid_cleared: got %b, expected 0", out_valid);
      else passCount++;
      checkCount++;
      if (out_data !== 16'h0000) $display("[TB] FAIL rstmid_data_cleared: got %h, expected 0000", out_data);
      else passCount++;
      checkCount++;
      if (in_ready !== 1'b1) $display("[TB] FAIL rstmid_in_ready: got %b, expected 1", in_ready);
      else passCount++;
      in_valid = 1'b1;
      in_op    = 3'd4;
      in_data  = 16'h00F0;
      in_amt   = 4'd4;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkCount++;
      if (out_valid !== 1'b0) $display("[TB] FAIL rstmid_dropped: got out_valid %b, expected 0", out_valid);
      else passCount++;
      @(posedge clk); #3;
      rst_n  = 1'b1;
      x.data = 16'h000F;
      x.err  = 1'b0;
      sbq.push_back(x);
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges    = 1;
      while (!out_valid && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      x = sbq.pop_front();
      checkCount++;
      if (edges !== SHW16) $display("[TB] FAIL rstmid_first_accept: got %0d edges, expected %0d", edges, SHW16);
      else passCount++;
      checkCount++;
      if (out_data !== x.data) $display("[TB] FAIL rstmid_new_data: got %h, expected %h", out_data, x.data);
      else passCount++;
   endtask

   task automatic test_width_sweep();
      int          w;
      int          shw;
      int          amt;
      int          edges;
      logic [63:0] mask;
      logic [63:0] a;
      logic [63:0] expv;
      logic [2:0]  op;
      for (int wi = 0; wi < 3; wi++) begin
         w    = (wi == 0) ? 4 : (wi == 1) ? 32 : 64;
         shw  = $clog2(w);
         mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
         for (int n = 0; n < 8; n++) begin
            op  = 3'($urandom_range(0, 4));
            amt = (n == 0) ? 0 : (n == 1) ? w - 1 : int'($urandom_range(0, w - 1));
            a   = {$urandom, $urandom} & mask;
            swq.push_back(refShift(w, op, a, amt));
            @(posedge clk); #1;
            swInValid[wi] = 1'b1;
            swInData[wi]  = a;
            swInAmt[wi]   = 6'(amt);
            swInOp[wi]    = op;
            @(posedge clk); #1;
            swInValid[wi] = 1'b0;
            edges         = 1;
            while (!swOutValid[wi] && edges < 100) begin
               @(posedge clk); #1;
               edges++;
            end
            expv = swq.pop_front();
            checkCount++;
            if (edges !== shw) $display("[TB] FAIL sweep_latency[w%0d,%0d]: got %0d edges, expected %0d", w, n, edges, shw);
            else passCount++;
            checkCount++;
            if (swOutData[wi] !== expv) $display("[TB] FAIL sweep_data[w%0d,%0d] op %0d amt %0d: got %h, expected %h", w, n, op, amt, swOutData[wi], expv);
            else passCount++;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clk       = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      in_op     = '0;
      out_ready = 1'b1;
      swInValid = '0;
      swInData  = '0;
      swInAmt   = '0;
      swInOp    = '0;
      test_reset();
      test_basic_ops();
      test_rotates();
      test_reserved_op();
      test_back_to_back();
      test_reset_mid();
      test_width_sweep();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
